mem_wb: RTL and testbench

Memory-access and write-back stage of the RV32I pipeline, sitting after execute. It takes one instruction at a time from execute and either forwards the ALU result or performs a load/store on the data-memory bus. Load data is aligned and sign/zero-extended. The result is written into the integer register file through the `RegWrite`/`rd`/`Writedata` port triple that decode's register file consumes.

---
 rtl/mem_wb.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_wb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// mem_wb: memory-access / write-back stage of the RV32I pipeline.
// An instruction from execute either passes its ALU result straight to
// write-back, or becomes one load/store transaction on the data-memory bus.
// Load data is lane-selected and sign/zero-extended before write-back.
//
// Ports
//   clk, clr              clock (rising edge), synchronous active-low reset
//   ex_valid / ex_ready   handshake with execute (accept on valid & ready)
//   alu_result            ALU result, or effective address for load/store
//   store_data            rs2 value for stores
//   ex_rd, func3          destination register, access width/sign
//   is_load, is_store     access type (never both)
//   reg_write             instruction writes rd
//   mem_req/we/addr/wdata/wstrb   registered data-memory request
//   mem_ack, mem_rdata    memory completion and load word
//   RegWrite, rd, Writedata       register-file write port (one-cycle pulse)
//   misalign              one-cycle pulse for misaligned/illegal access
//
// state | meaning
// IDLE  | no instruction in flight, ready to accept
// MEM   | memory request outstanding, waiting for mem_ack
// WB    | write-back outputs valid this cycle, ready to accept
module mem_wb (
  input  logic        clk,
  input  logic        clr,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  func3,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] Writedata,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        misalign_q, misalign_d;

  // Load bookkeeping carried from accept to mem_ack.
  logic        pend_load_q, pend_load_d;
  logic        pend_rw_q, pend_rw_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [2:0]  pend_f3_q, pend_f3_d;
  logic [1:0]  pend_lo_q, pend_lo_d;

  logic        is_mem;
  logic        size_ok;
  logic        f3_ok;
  logic        access_ok;
  logic [1:0]  addr_lo;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ex_ready  = (state_q != MEM);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign RegWrite  = reg_write_q;
  assign rd        = rd_q;
  assign Writedata = wdata_q;
  assign misalign  = misalign_q;

  assign is_mem  = is_load | is_store;
  assign addr_lo = alu_result[1:0];

  // Access legality: width alignment plus the func3 codes defined per type.
  always_comb begin
    size_ok = 1'b0;
    case (func3[1:0])
      2'b00:   size_ok = 1'b1;
      2'b01:   size_ok = ~addr_lo[0];
      2'b10:   size_ok = (addr_lo == 2'b00);
      default: size_ok = 1'b0;
    endcase
    if (is_load) f3_ok = (func3 != 3'b011) && (func3[2:1] != 2'b11);
    else         f3_ok = (func3[2] == 1'b0) && (func3[1:0] != 2'b11);
    access_ok = size_ok & f3_ok;
  end

  // Store lanes: data replicated so the byte enables alone pick the lane.
  always_comb begin
    st_wdata = store_data;
    st_wstrb = 4'b1111;
    case (func3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << addr_lo;
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << addr_lo;
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (pend_lo_q)
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = pend_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (pend_f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    misalign_d  = 1'b0;
    pend_load_d = pend_load_q;
    pend_rw_d   = pend_rw_q;
    pend_rd_d   = pend_rd_q;
    pend_f3_d   = pend_f3_q;
    pend_lo_d   = pend_lo_q;

    case (state_q)
      IDLE, WB: begin
        state_d = IDLE;
        if (ex_valid) begin
          if (!is_mem) begin
            state_d     = WB;
            reg_write_d = reg_write & (ex_rd != 5'd0);
            rd_d        = ex_rd;
            wdata_d     = alu_result;
          end else if (access_ok) begin
            state_d     = MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {alu_result[31:2], 2'b00};
            mem_wdata_d = is_store ? st_wdata : 32'h0;
            mem_wstrb_d = is_store ? st_wstrb : 4'b0000;
            pend_load_d = is_load;
            pend_rw_d   = reg_write;
            pend_rd_d   = ex_rd;
            pend_f3_d   = func3;
            pend_lo_d   = addr_lo;
          end else begin
            // Bad access retires as a bubble through WB with a flag.
            state_d    = WB;
            misalign_d = 1'b1;
          end
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_d     = WB;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          if (pend_load_q) begin
            reg_write_d = pend_rw_q & (pend_rd_q != 5'd0);
            rd_d        = pend_rd_q;
            wdata_d     = ld_ext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      wdata_q     <= 32'h0;
      misalign_q  <= 1'b0;
      pend_load_q <= 1'b0;
      pend_rw_q   <= 1'b0;
      pend_rd_q   <= 5'd0;
      pend_f3_q   <= 3'b000;
      pend_lo_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      misalign_q  <= misalign_d;
      pend_load_q <= pend_load_d;
      pend_rw_q   <= pend_rw_d;
      pend_rd_q   <= pend_rd_d;
      pend_f3_q   <= pend_f3_d;
      pend_lo_q   <= pend_lo_d;
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        clr;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  func3;
  logic        is_load;
  logic        is_store;
  logic        reg_write;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] Writedata;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb dut (
    .clk(clk), .clr(clr), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .store_data(store_data), .ex_rd(ex_rd),
    .func3(func3), .is_load(is_load), .is_store(is_store),
    .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .RegWrite(RegWrite),
    .rd(rd), .Writedata(Writedata), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rdn;
    logic        rw;
    logic [31:0] rdata;
    int          waits;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_rw;
    logic [31:0] e_wd;
    logic        e_mis;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rdn, input logic rw);
    ex_valid   = 1'b1;
    is_load    = ld;
    is_store   = st;
    func3      = f3;
    alu_result = addr;
    store_data = sd;
    ex_rd      = rdn;
    reg_write  = rw;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    drive(v.ld, v.st, v.f3, v.addr, v.sd, v.rdn, v.rw);
    tick();
    ex_valid = 1'b0;
    chk({p, ".mem_req"}, {31'h0, mem_req}, {31'h0, v.e_req});
    if (v.e_req) begin
      chk({p, ".mem_we"}, {31'h0, mem_we}, {31'h0, v.e_we});
      chk({p, ".mem_addr"}, mem_addr, v.e_addr);
      chk({p, ".mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, v.e_wstrb});
      if (v.e_we) chk({p, ".mem_wdata"}, mem_wdata, v.e_wdata);
      chk({p, ".ex_ready_mem"}, {31'h0, ex_ready}, 32'h0);
      for (int w = 0; w < v.waits; w++) begin
        tick();
        chk({p, ".req_hold"}, {31'h0, mem_req}, 32'h1);
        chk({p, ".addr_hold"}, mem_addr, v.e_addr);
        chk({p, ".ex_ready_wait"}, {31'h0, ex_ready}, 32'h0);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'hA5A5_A5A5;
      chk({p, ".req_drop"}, {31'h0, mem_req}, 32'h0);
    end
    chk({p, ".misalign"}, {31'h0, misalign}, {31'h0, v.e_mis});
    chk({p, ".RegWrite"}, {31'h0, RegWrite}, {31'h0, v.e_rw});
    chk({p, ".ex_ready_wb"}, {31'h0, ex_ready}, 32'h1);
    if (v.e_rw) begin
      chk({p, ".rd"}, {27'h0, rd}, {27'h0, v.rdn});
      chk({p, ".Writedata"}, Writedata, v.e_wd);
    end
    tick();
    chk({p, ".RegWrite_idle"}, {31'h0, RegWrite}, 32'h0);
    chk({p, ".misalign_idle"}, {31'h0, misalign}, 32'h0);
  endtask

  initial begin
    //          ld  st  f3      addr          sd            rd     rw  rdata         w  req we  e_addr        e_wdata       strb     rw  e_wd          mis
    vecs[0]  = '{0, 0, 3'b000, 32'h1234_5678, 32'h0,        5'd5,  1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 1, 32'h1234_5678, 0};
    vecs[1]  = '{0, 0, 3'b000, 32'h0BAD_F00D, 32'h0,        5'd0,  1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        0};
    vecs[2]  = '{1, 0, 3'b000, 32'h0000_0103, 32'h0,        5'd7,  1, 32'h80AA_BBCC, 3, 1, 0, 32'h0000_0100, 32'h0,       4'b0000, 1, 32'hFFFF_FF80, 0};
    vecs[3]  = '{1, 0, 3'b100, 32'h0000_0103, 32'h0,        5'd8,  1, 32'h80AA_BBCC, 3, 1, 0, 32'h0000_0100, 32'h0,       4'b0000, 1, 32'h0000_0080, 0};
    vecs[4]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd9, 1, 32'h0,        0, 1, 1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 0, 32'h0,        0};
    vecs[5]  = '{1, 0, 3'b010, 32'h0000_0301, 32'h0,        5'd10, 1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        1};
    vecs[6]  = '{1, 0, 3'b001, 32'h0000_0002, 32'h0,        5'd11, 1, 32'h8001_7F00, 0, 1, 0, 32'h0,       32'h0,        4'b0000, 1, 32'hFFFF_8001, 0};
    vecs[7]  = '{1, 0, 3'b101, 32'h0000_0002, 32'h0,        5'd12, 1, 32'h8001_7F00, 0, 1, 0, 32'h0,       32'h0,        4'b0000, 1, 32'h0000_8001, 0};
    vecs[8]  = '{1, 0, 3'b010, 32'h0000_0400, 32'h0,        5'd13, 1, 32'hDEAD_BEEF, 1, 1, 0, 32'h0000_0400, 32'h0,       4'b0000, 1, 32'hDEAD_BEEF, 0};
    vecs[9]  = '{0, 1, 3'b000, 32'h0000_0011, 32'h1234_5678, 5'd1, 0, 32'h0,        0, 1, 1, 32'h0000_0010, 32'h7878_7878, 4'b0010, 0, 32'h0,        0};
    vecs[10] = '{0, 1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 5'd2, 0, 32'h0,        2, 1, 1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 0, 32'h0,        0};
    vecs[11] = '{1, 0, 3'b011, 32'h0000_0000, 32'h0,        5'd3,  1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        1};
    vecs[12] = '{0, 1, 3'b011, 32'h0000_0000, 32'h1111_1111, 5'd4, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        1};
    vecs[13] = '{1, 0, 3'b000, 32'h0000_0001, 32'h0,        5'd14, 1, 32'h0000_7F00, 0, 1, 0, 32'h0,       32'h0,        4'b0000, 1, 32'h0000_007F, 0};
    vecs[14] = '{1, 0, 3'b101, 32'h0000_0100, 32'h0,        5'd15, 1, 32'h1234_FEDC, 1, 1, 0, 32'h0000_0100, 32'h0,       4'b0000, 1, 32'h0000_FEDC, 0};

    clr = 1'b0; ex_valid = 1'b0; alu_result = 32'h0; store_data = 32'h0;
    ex_rd = 5'd0; func3 = 3'b000; is_load = 1'b0; is_store = 1'b0;
    reg_write = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst.ex_ready", {31'h0, ex_ready}, 32'h1);
    chk("rst.mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst.mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.RegWrite", {31'h0, RegWrite}, 32'h0);
    chk("rst.rd", {27'h0, rd}, 32'h0);
    chk("rst.Writedata", Writedata, 32'h0);
    chk("rst.misalign", {31'h0, misalign}, 32'h0);
    clr = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Back-to-back ALU, load (zero-wait ack), ALU
    drive(0, 0, 3'b000, 32'h0000_0011, 32'h0, 5'd1, 1);
    tick();
    chk("b2b.c1.RegWrite", {31'h0, RegWrite}, 32'h1);
    chk("b2b.c1.rd", {27'h0, rd}, 32'd1);
    chk("b2b.c1.Writedata", Writedata, 32'h11);
    chk("b2b.c1.ex_ready", {31'h0, ex_ready}, 32'h1);
    drive(1, 0, 3'b010, 32'h0000_0040, 32'h0, 5'd2, 1);
    tick();
    chk("b2b.c2.mem_req", {31'h0, mem_req}, 32'h1);
    chk("b2b.c2.ex_ready", {31'h0, ex_ready}, 32'h0);
    chk("b2b.c2.RegWrite", {31'h0, RegWrite}, 32'h0);
    drive(0, 0, 3'b000, 32'h0000_0033, 32'h0, 5'd3, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0022;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
    chk("b2b.c3.RegWrite", {31'h0, RegWrite}, 32'h1);
    chk("b2b.c3.rd", {27'h0, rd}, 32'd2);
    chk("b2b.c3.Writedata", Writedata, 32'h22);
    chk("b2b.c3.ex_ready", {31'h0, ex_ready}, 32'h1);
    chk("b2b.c3.mem_req", {31'h0, mem_req}, 32'h0);
    tick();
    ex_valid = 1'b0;
    chk("b2b.c4.RegWrite", {31'h0, RegWrite}, 32'h1);
    chk("b2b.c4.rd", {27'h0, rd}, 32'd3);
    chk("b2b.c4.Writedata", Writedata, 32'h33);
    tick();
    chk("b2b.c5.RegWrite", {31'h0, RegWrite}, 32'h0);

    // Misaligned LW followed immediately by an ALU op
    drive(1, 0, 3'b010, 32'h0000_0301, 32'h0, 5'd6, 1);
    tick();
    chk("mis.misalign", {31'h0, misalign}, 32'h1);
    chk("mis.mem_req", {31'h0, mem_req}, 32'h0);
    chk("mis.RegWrite", {31'h0, RegWrite}, 32'h0);
    chk("mis.ex_ready", {31'h0, ex_ready}, 32'h1);
    drive(0, 0, 3'b000, 32'h0000_0044, 32'h0, 5'd4, 1);
    tick();
    ex_valid = 1'b0;
    chk("mis.alu.RegWrite", {31'h0, RegWrite}, 32'h1);
    chk("mis.alu.rd", {27'h0, rd}, 32'd4);
    chk("mis.alu.Writedata", Writedata, 32'h44);
    chk("mis.alu.misalign", {31'h0, misalign}, 32'h0);
    tick();

    // Reset while waiting in MEM; a late ack must be ignored
    drive(1, 0, 3'b010, 32'h0000_0080, 32'h0, 5'd6, 1);
    tick();
    ex_valid = 1'b0;
    chk("rmem.mem_req_before", {31'h0, mem_req}, 32'h1);
    clr = 1'b0;
    tick();
    chk("rmem.mem_req", {31'h0, mem_req}, 32'h0);
    chk("rmem.RegWrite", {31'h0, RegWrite}, 32'h0);
    chk("rmem.ex_ready", {31'h0, ex_ready}, 32'h1);
    chk("rmem.mem_addr", mem_addr, 32'h0);
    clr = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    tick();
    mem_ack = 1'b0;
    chk("rmem.late_ack.RegWrite", {31'h0, RegWrite}, 32'h0);
    chk("rmem.late_ack.mem_req", {31'h0, mem_req}, 32'h0);
    tick();
    chk("rmem.after.RegWrite", {31'h0, RegWrite}, 32'h0);
    chk("rmem.after.Writedata", Writedata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
